// File: rtl/tcam_route_if.sv
// Command and hit-stream bundle for the routing TCAM.
// The master side issues commands and accepts hit beats. The slave side is the TCAM.
interface tcam_route_if #(
    parameter int ID_Width      = 4,
    parameter int Axon_Width    = 2,
    parameter int Synapse_Width = 2,
    parameter int Weight_Width  = 4,
    parameter int Words         = 16
);
    localparam int AddressSize = $clog2(Words);
    localparam int Bits        = ID_Width + Axon_Width + Synapse_Width;

    logic [2:0]                       MODE;
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [ID_Width-1:0]              PacketID_In;
    logic [Bits-1:0]                  Data_In;
    logic [Bits-1:0]                  Mskb_In;
    logic [ID_Width+Weight_Width-1:0] Payload_In;
    logic [AddressSize-1:0]           A_In;
    logic                             Vbi_In;
    logic [Bits-1:0]                  DO;
    logic [Bits-1:0]                  Mko_Out;
    logic                             Vbo_Out;
    logic [ID_Width-1:0]              DstID_Out;
    logic [Weight_Width-1:0]          Weight_Out;
    logic [AddressSize-1:0]           Addr_Out;
    logic                             out_valid;
    logic                             out_ready;
    logic [AddressSize:0]             Hit_Count;
    logic                             Done;

    modport master (
        output MODE, cmd_valid, PacketID_In, Data_In, Mskb_In, Payload_In, A_In, Vbi_In, out_ready,
        input  cmd_ready, DO, Mko_Out, Vbo_Out, DstID_Out, Weight_Out, Addr_Out, out_valid,
               Hit_Count, Done
    );

    modport slave (
        input  MODE, cmd_valid, PacketID_In, Data_In, Mskb_In, Payload_In, A_In, Vbi_In, out_ready,
        output cmd_ready, DO, Mko_Out, Vbo_Out, DstID_Out, Weight_Out, Addr_Out, out_valid,
               Hit_Count, Done
    );
endinterface

// File: rtl/tcam_route_mem.sv
// Masked-key routing TCAM. A fire or compare lookup registers a hit vector.
// Every hit is then streamed in ascending address order, one beat per cycle.
//  state    | meaning
//  S_IDLE   | waiting for a command, cmd_ready high
//  S_WRITE  | commit the latched entry to the table
//  S_READ   | register key/mask/valid of the latched address
//  S_MATCH  | evaluate all entries, latch hit vector and count
//  S_STREAM | present lowest remaining hit until the vector drains
//  S_FLUSH  | clear every valid bit
//  S_DONE   | one-cycle Done pulse
module tcam_route_mem #(
    parameter int ID_Width      = 4,
    parameter int Axon_Width    = 2,
    parameter int Synapse_Width = 2,
    parameter int Weight_Width  = 4,
    parameter int Words         = 16
) (
    input logic          clk,
    input logic          rst_n,
    tcam_route_if.slave  bus
);
    localparam int AddressSize = $clog2(Words);
    localparam int Bits        = ID_Width + Axon_Width + Synapse_Width;
    localparam int PayW        = ID_Width + Weight_Width;
    localparam int AxSy        = Axon_Width + Synapse_Width;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_MATCH  = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [2:0] M_WRITE  = 3'b001;
    localparam logic [2:0] M_READ   = 3'b010;
    localparam logic [2:0] M_FIRE   = 3'b011;
    localparam logic [2:0] M_CMP    = 3'b100;
    localparam logic [2:0] M_FLUSH  = 3'b101;

    logic [2:0]             state;
    logic [AddressSize-1:0] a_q;
    logic [Bits-1:0]        key_q;
    logic [Bits-1:0]        mask_q;
    logic [PayW-1:0]        pay_q;
    logic                   vbi_q;

    logic [Bits-1:0]        key_mem  [Words];
    logic [Bits-1:0]        care_mem [Words];
    logic [PayW-1:0]        pay_mem  [Words];
    logic [Words-1:0]       valid_q;
    logic [Words-1:0]       hit_q;
    logic [AddressSize:0]   hit_cnt_q;
    logic [Bits-1:0]        do_q;
    logic [Bits-1:0]        mko_q;
    logic                   vbo_q;

    logic [Words-1:0]       hit_next;
    logic [AddressSize:0]   cnt_next;
    logic [AddressSize-1:0] sel_idx;
    logic                   sel_found;
    logic [Words-1:0]       hit_rest;
    logic                   beat;

    // key_q/mask_q double as search key/search mask during a lookup
    always_comb begin
        hit_next = '0;
        cnt_next = '0;
        for (int i = 0; i < Words; i++) begin
            hit_next[i] = valid_q[i] && (((key_mem[i] ^ key_q) & care_mem[i] & mask_q) == '0);
            cnt_next    = cnt_next + (AddressSize+1)'(hit_next[i]);
        end
    end

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < Words; i++) begin
            if (hit_q[i] && !sel_found) begin
                sel_idx   = AddressSize'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign hit_rest = hit_q & ~(Words'(1) << sel_idx);
    assign beat     = (state == S_STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            key_q     <= '0;
            mask_q    <= '0;
            pay_q     <= '0;
            vbi_q     <= 1'b0;
            valid_q   <= '0;
            hit_q     <= '0;
            hit_cnt_q <= '0;
            do_q      <= '0;
            mko_q     <= '0;
            vbo_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        a_q   <= bus.A_In;
                        pay_q <= bus.Payload_In;
                        vbi_q <= bus.Vbi_In;
                        if (bus.MODE == M_FIRE) begin
                            key_q  <= {bus.PacketID_In, {AxSy{1'b0}}};
                            mask_q <= {{ID_Width{1'b1}}, {AxSy{1'b0}}};
                        end else begin
                            key_q  <= bus.Data_In;
                            mask_q <= bus.Mskb_In;
                        end
                        case (bus.MODE)
                            M_WRITE:        state <= S_WRITE;
                            M_READ:         state <= S_READ;
                            M_FIRE, M_CMP:  state <= S_MATCH;
                            M_FLUSH:        state <= S_FLUSH;
                            default:        state <= S_DONE;
                        endcase
                    end
                end
                S_WRITE: begin
                    valid_q[a_q] <= vbi_q;
                    state        <= S_DONE;
                end
                S_READ: begin
                    do_q  <= key_mem[a_q];
                    mko_q <= care_mem[a_q];
                    vbo_q <= valid_q[a_q];
                    state <= S_DONE;
                end
                S_MATCH: begin
                    hit_q     <= hit_next;
                    hit_cnt_q <= cnt_next;
                    state     <= (hit_next != '0) ? S_STREAM : S_DONE;
                end
                S_STREAM: begin
                    if (bus.out_ready) begin
                        hit_q <= hit_rest;
                        if (hit_rest == '0)
                            state <= S_DONE;
                    end
                end
                S_FLUSH: begin
                    valid_q <= '0;
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // table contents are not reset; only valid bits qualify them
    always_ff @(posedge clk) begin
        if (state == S_WRITE) begin
            key_mem[a_q]  <= key_q;
            care_mem[a_q] <= mask_q;
            pay_mem[a_q]  <= pay_q;
        end
    end

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.Done       = (state == S_DONE);
    assign bus.out_valid  = beat;
    assign bus.Addr_Out   = beat ? sel_idx : '0;
    assign bus.DstID_Out  = beat ? pay_mem[sel_idx][PayW-1:Weight_Width] : '0;
    assign bus.Weight_Out = beat ? pay_mem[sel_idx][Weight_Width-1:0] : '0;
    assign bus.Hit_Count  = hit_cnt_q;
    assign bus.DO         = do_q;
    assign bus.Mko_Out    = mko_q;
    assign bus.Vbo_Out    = vbo_q;
endmodule
